// File: rtl/mem_arbiter_pkg.sv
// Shared types for the byte-wide RAM port arbiter: FSM states, grant owner,
// LSB access size codes and the size -> byte count mapping.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    MA_IDLE  = 2'd0,
    MA_IC_RD = 2'd1,
    MA_LS_RD = 2'd2,
    MA_LS_WR = 2'd3
  } state_t;

  typedef enum logic {
    GR_IC  = 1'b0,
    GR_LSB = 1'b1
  } grant_t;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  // Bytes per access; the reserved size code 11 behaves as a word.
  function automatic logic [2:0] byte_count(input logic [1:0] size);
    case (size)
      SZ_B:    return 3'd1;
      SZ_H:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter_byte_assembler.sv
// mem_byte_assembler: collects up to four RAM bytes little-endian into a
// 32-bit word. The word is zeroed when a new access starts, so bytes beyond
// the access size read back as 0. word_nxt already includes the byte being
// captured this cycle, letting the owner return data on the final edge.
import mem_arbiter_pkg::*;

module mem_byte_assembler (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [1:0]  load_size,
  input  logic        cap,
  input  logic [1:0]  idx,
  input  logic [7:0]  din,
  output logic [2:0]  nbytes,
  output logic [31:0] word_nxt
);

  logic [31:0] word;
  logic [1:0]  size_q;

  // Latch access size and clear the word on start; insert bytes on capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      word   <= '0;
      size_q <= SZ_B;
    end else if (load) begin
      word   <= '0;
      size_q <= load_size;
    end else if (cap) begin
      word   <= word_nxt;
    end
  end

  // Merge the incoming byte into its lane.
  always_comb begin
    word_nxt = word;
    if (cap) word_nxt[{idx, 3'b000} +: 8] = din;
  end

  assign nbytes = byte_count(size_q);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: owns the byte-wide RAM port, alternating between I-cache
// refills (4-byte reads) and the load/store buffer (1/2/4-byte reads and
// writes). Each request is split into consecutive byte accesses.
// Optional build macro MEM_ARBITER_IO_STALL_EN: holds store bytes aimed at the
// IO region (addr[17:16] == IO_HI) while the UART FIFO reports full.
import mem_arbiter_pkg::*;

module mem_arbiter #(
  parameter int         ADDR_W = 32,
  parameter logic [1:0] IO_HI  = 2'b11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              clear,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic              ic_done,
  output logic [31:0]       ic_data,
  input  logic              lsb_req,
  input  logic              lsb_wr,
  input  logic [1:0]        lsb_size,
  input  logic [ADDR_W-1:0] lsb_addr,
  input  logic [31:0]       lsb_wdata,
  output logic              lsb_done,
  output logic [31:0]       lsb_rdata,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              io_buffer_full
);

  state_t            state;
  grant_t            last_grant;
  logic [2:0]        cnt;
  logic [ADDR_W-1:0] base;
  logic [31:0]       wdata_q;
  logic              wr_q;

  logic        ic_v, ls_v, grant_ic, grant_ls;
  logic        asm_load, asm_cap, last, is_io, io_stall;
  logic [1:0]  asm_idx;
  logic [2:0]  nbytes;
  logic [31:0] asm_word;

  // A port whose done is high this cycle is not eligible again yet.
  assign ic_v     = ic_req  && !ic_done;
  assign ls_v     = lsb_req && !lsb_done;
  assign grant_ic = ic_v && (!ls_v || last_grant == GR_LSB);
  assign grant_ls = ls_v && !grant_ic;

  assign last     = (cnt == nbytes);
  assign asm_idx  = cnt[1:0] - 2'd1;
  assign asm_load = rdy && !clear && state == MA_IDLE && (grant_ic || grant_ls);
  assign asm_cap  = rdy && !clear && (state == MA_IC_RD || state == MA_LS_RD);
  assign is_io    = (base[17:16] == IO_HI);

`ifdef MEM_ARBITER_IO_STALL_EN
  assign io_stall = (state == MA_LS_WR) && is_io && io_buffer_full;
`else
  // Feature off: stores never wait on the UART FIFO.
  assign io_stall = is_io & io_buffer_full & 1'b0;
`endif

  // A held byte (rdy low or IO stall) is simply not strobed; it goes out
  // again unchanged once the hold lifts.
  assign mem_wr = wr_q && rdy && !io_stall;

  mem_byte_assembler u_asm (
    .clk       (clk),
    .rst       (rst),
    .load      (asm_load),
    .load_size (grant_ic ? SZ_W : lsb_size),
    .cap       (asm_cap),
    .idx       (asm_idx),
    .din       (mem_din),
    .nbytes    (nbytes),
    .word_nxt  (asm_word)
  );

  // Arbitration, byte sequencing and done/data return.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= MA_IDLE;
      last_grant <= GR_LSB;
      cnt        <= '0;
      base       <= '0;
      wdata_q    <= '0;
      wr_q       <= 1'b0;
      mem_a      <= '0;
      mem_dout   <= '0;
      ic_done    <= 1'b0;
      ic_data    <= '0;
      lsb_done   <= 1'b0;
      lsb_rdata  <= '0;
    end else begin
      ic_done  <= 1'b0;
      lsb_done <= 1'b0;
      if (rdy) begin
        case (state)
          MA_IDLE: begin
            if (!clear && grant_ic) begin
              state      <= MA_IC_RD;
              last_grant <= GR_IC;
              base       <= ic_addr;
              mem_a      <= ic_addr;
              wr_q       <= 1'b0;
              cnt        <= 3'd1;
            end else if (!clear && grant_ls) begin
              state      <= lsb_wr ? MA_LS_WR : MA_LS_RD;
              last_grant <= GR_LSB;
              base       <= lsb_addr;
              mem_a      <= lsb_addr;
              wdata_q    <= lsb_wdata;
              mem_dout   <= lsb_wdata[7:0];
              wr_q       <= lsb_wr;
              cnt        <= 3'd1;
            end
          end
          MA_IC_RD, MA_LS_RD: begin
            if (clear) begin
              state <= MA_IDLE;
              cnt   <= '0;
              wr_q  <= 1'b0;
            end else if (last) begin
              state <= MA_IDLE;
              cnt   <= '0;
              if (state == MA_IC_RD) begin
                ic_done <= 1'b1;
                ic_data <= asm_word;
              end else begin
                lsb_done  <= 1'b1;
                lsb_rdata <= asm_word;
              end
            end else begin
              mem_a <= base + ADDR_W'(cnt);
              cnt   <= cnt + 3'd1;
            end
          end
          MA_LS_WR: begin
            // Stores are already committed, so a flush does not stop them.
            if (!io_stall) begin
              if (last) begin
                state    <= MA_IDLE;
                cnt      <= '0;
                wr_q     <= 1'b0;
                lsb_done <= 1'b1;
              end else begin
                mem_a    <= base + ADDR_W'(cnt);
                mem_dout <= wdata_q[{cnt[1:0], 3'b000} +: 8];
                cnt      <= cnt + 3'd1;
              end
            end
          end
          default: state <= MA_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: scoreboard queues hold expected read
// words and expected RAM writes; each scenario task compares them inline.
module tb_mem_arbiter;

  typedef logic [39:0] wrec_t;

  logic        clk = 1'b0;
  logic        rst, rdy, clear;
  logic        ic_req, ic_done;
  logic [31:0] ic_addr, ic_data;
  logic        lsb_req, lsb_wr, lsb_done;
  logic [1:0]  lsb_size;
  logic [31:0] lsb_addr, lsb_wdata, lsb_rdata;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr, io_buffer_full;

  logic [7:0]  ram [0:4095];
  wrec_t       wlog[$];
  int          ic_dones = 0;

  logic [31:0] exp_ic[$];
  logic [31:0] exp_ls[$];
  wrec_t       exp_wr[$];

  int compared = 0;
  int mismatched = 0;

  mem_arbiter #(.ADDR_W(32), .IO_HI(2'b11)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_done(ic_done), .ic_data(ic_data),
    .lsb_req(lsb_req), .lsb_wr(lsb_wr), .lsb_size(lsb_size), .lsb_addr(lsb_addr),
    .lsb_wdata(lsb_wdata), .lsb_done(lsb_done), .lsb_rdata(lsb_rdata),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  always #5 clk = ~clk;

  // RAM read side: byte for the address presented since the previous edge.
  assign mem_din = ram[mem_a[11:0]];

  // Record every byte strobed into RAM and count I-cache done pulses.
  always @(posedge clk) begin
    if (mem_wr === 1'b1) wlog.push_back({mem_a, mem_dout});
    if (ic_done === 1'b1) ic_dones++;
  end

  task automatic apply_reset;
    rst = 1'b1; rdy = 1'b1; clear = 1'b0; io_buffer_full = 1'b0;
    ic_req = 1'b0; lsb_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_done(input bit is_ic, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (((is_ic ? ic_done : lsb_done) !== 1'b1) && lat < 60);
  endtask

  task automatic test_reset;
    apply_reset();
    rst = 1'b1;
    @(negedge clk);
    compared++;
    if ({ic_done, lsb_done, mem_wr} !== 3'b000) begin
      mismatched++;
      $display("FAIL reset_strobes: got %b expected 000", {ic_done, lsb_done, mem_wr});
    end
    compared++;
    if ({mem_a, mem_dout} !== 40'h0) begin
      mismatched++;
      $display("FAIL reset_bus: got a=%h dout=%h expected 0", mem_a, mem_dout);
    end
    compared++;
    if ({ic_data, lsb_rdata} !== 64'h0) begin
      mismatched++;
      $display("FAIL reset_data: got ic=%h lsb=%h expected 0", ic_data, lsb_rdata);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ic_read;
    int lat;
    logic [31:0] e;
    ram[12'h100] = 8'h13; ram[12'h101] = 8'h05; ram[12'h102] = 8'hA0; ram[12'h103] = 8'h00;
    ic_addr = 32'h100; ic_req = 1'b1;
    exp_ic.push_back(32'h00A00513);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      compared++;
      if (mem_a !== 32'h100 + k || mem_wr !== 1'b0) begin
        mismatched++;
        $display("FAIL ic_addr_seq[%0d]: got a=%h wr=%b expected a=%h wr=0", k, mem_a, mem_wr, 32'h100 + k);
      end
    end
    wait_done(1'b1, lat);
    lat += 4;
    compared++;
    if (lat !== 5) begin
      mismatched++;
      $display("FAIL ic_latency: got %0d expected 5", lat);
    end
    e = exp_ic.pop_front();
    compared++;
    if (ic_data !== e) begin
      mismatched++;
      $display("FAIL ic_data: got %h expected %h", ic_data, e);
    end
    // Request still held through the done cycle must not start a new fetch.
    @(negedge clk);
    compared++;
    if (mem_a !== 32'h103 || ic_done !== 1'b0) begin
      mismatched++;
      $display("FAIL ic_req_ignored_on_done: got a=%h done=%b expected a=00000103 done=0", mem_a, ic_done);
    end
    ic_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_store_half;
    int lat, w0;
    wrec_t e;
    w0 = wlog.size();
    lsb_wr = 1'b1; lsb_size = 2'b01; lsb_addr = 32'h200; lsb_wdata = 32'h1234ABCD; lsb_req = 1'b1;
    exp_wr.push_back({32'h200, 8'hCD});
    exp_wr.push_back({32'h201, 8'hAB});
    wait_done(1'b0, lat);
    lsb_req = 1'b0;
    compared++;
    if (lat !== 3) begin
      mismatched++;
      $display("FAIL store_half_latency: got %0d expected 3", lat);
    end
    compared++;
    if (wlog.size() - w0 !== 2) begin
      mismatched++;
      $display("FAIL store_half_count: got %0d writes expected 2", wlog.size() - w0);
    end
    for (int i = 0; exp_wr.size() > 0; i++) begin
      e = exp_wr.pop_front();
      compared++;
      if (w0 + i >= wlog.size() || wlog[w0 + i] !== e) begin
        mismatched++;
        $display("FAIL store_half_byte[%0d]: got %h expected %h", i,
                 (w0 + i < wlog.size()) ? wlog[w0 + i] : 40'h0, e);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_arbitration;
    int lat;
    logic [31:0] e;
    apply_reset();
    ram[12'h300] = 8'h9C;
    ram[12'h500] = 8'h11; ram[12'h501] = 8'h22; ram[12'h502] = 8'h33; ram[12'h503] = 8'h44;
    exp_ic.push_back(32'h44332211);
    exp_ls.push_back(32'h0000009C);
    ic_addr = 32'h500; ic_req = 1'b1;
    lsb_wr = 1'b0; lsb_size = 2'b00; lsb_addr = 32'h300; lsb_req = 1'b1;
    @(negedge clk);
    compared++;
    if (mem_a !== 32'h500) begin
      mismatched++;
      $display("FAIL arb_ic_first: got a=%h expected 00000500", mem_a);
    end
    wait_done(1'b1, lat);
    lat += 1;
    compared++;
    if (lat !== 5) begin
      mismatched++;
      $display("FAIL arb_ic_latency: got %0d expected 5", lat);
    end
    e = exp_ic.pop_front();
    compared++;
    if (ic_data !== e) begin
      mismatched++;
      $display("FAIL arb_ic_data: got %h expected %h", ic_data, e);
    end
    ic_req = 1'b0;
    @(negedge clk);
    compared++;
    if (mem_a !== 32'h300) begin
      mismatched++;
      $display("FAIL arb_lsb_after_done: got a=%h expected 00000300", mem_a);
    end
    wait_done(1'b0, lat);
    lsb_req = 1'b0;
    compared++;
    if (lat !== 1) begin
      mismatched++;
      $display("FAIL arb_lsb_latency: got %0d expected 1", lat);
    end
    e = exp_ls.pop_front();
    compared++;
    if (lsb_rdata !== e) begin
      mismatched++;
      $display("FAIL arb_lsb_rdata: got %h expected %h", lsb_rdata, e);
    end
    @(negedge clk);
  endtask

  task automatic test_clear;
    int lat, d0, w0;
    logic [31:0] prev;
    wrec_t e;
    prev = ic_data;
    d0 = ic_dones;
    ic_addr = 32'h400; ic_req = 1'b1;
    repeat (3) @(negedge clk);
    compared++;
    if (mem_a !== 32'h402) begin
      mismatched++;
      $display("FAIL clear_setup: got a=%h expected 00000402", mem_a);
    end
    clear = 1'b1; ic_req = 1'b0;
    @(negedge clk);
    clear = 1'b0;
    repeat (6) @(negedge clk);
    compared++;
    if (ic_dones - d0 !== 0 || ic_data !== prev) begin
      mismatched++;
      $display("FAIL clear_read_abort: got %0d done pulses data=%h expected 0 pulses data=%h",
               ic_dones - d0, ic_data, prev);
    end
    // Flush during a word store: every byte still lands.
    w0 = wlog.size();
    lsb_wr = 1'b1; lsb_size = 2'b10; lsb_addr = 32'h600; lsb_wdata = 32'hDEADBEEF; lsb_req = 1'b1;
    exp_wr.push_back({32'h600, 8'hEF});
    exp_wr.push_back({32'h601, 8'hBE});
    exp_wr.push_back({32'h602, 8'hAD});
    exp_wr.push_back({32'h603, 8'hDE});
    repeat (2) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    wait_done(1'b0, lat);
    lsb_req = 1'b0;
    lat += 3;
    compared++;
    if (lat !== 5) begin
      mismatched++;
      $display("FAIL clear_store_latency: got %0d expected 5", lat);
    end
    for (int i = 0; exp_wr.size() > 0; i++) begin
      e = exp_wr.pop_front();
      compared++;
      if (w0 + i >= wlog.size() || wlog[w0 + i] !== e) begin
        mismatched++;
        $display("FAIL clear_store_byte[%0d]: got %h expected %h", i,
                 (w0 + i < wlog.size()) ? wlog[w0 + i] : 40'h0, e);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_rdy_stall;
    int lat, w0;
    logic [31:0] e;
    ram[12'h700] = 8'h78; ram[12'h701] = 8'h56; ram[12'h702] = 8'h34; ram[12'h703] = 8'h12;
    exp_ic.push_back(32'h12345678);
    ic_addr = 32'h700; ic_req = 1'b1;
    repeat (2) @(negedge clk);
    rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      compared++;
      if (mem_a !== 32'h701 || mem_wr !== 1'b0) begin
        mismatched++;
        $display("FAIL rdy_freeze[%0d]: got a=%h wr=%b expected a=00000701 wr=0", k, mem_a, mem_wr);
      end
    end
    rdy = 1'b1;
    wait_done(1'b1, lat);
    ic_req = 1'b0;
    lat += 5;
    compared++;
    if (lat !== 8) begin
      mismatched++;
      $display("FAIL rdy_latency: got %0d expected 8", lat);
    end
    e = exp_ic.pop_front();
    compared++;
    if (ic_data !== e) begin
      mismatched++;
      $display("FAIL rdy_data: got %h expected %h", ic_data, e);
    end
    @(negedge clk);
    // A store byte held by rdy low is strobed once after resume.
    w0 = wlog.size();
    lsb_wr = 1'b1; lsb_size = 2'b00; lsb_addr = 32'h800; lsb_wdata = 32'h55; lsb_req = 1'b1;
    @(negedge clk);
    rdy = 1'b0;
    #1;
    compared++;
    if (mem_wr !== 1'b0) begin
      mismatched++;
      $display("FAIL rdy_forces_wr_low: got %b expected 0", mem_wr);
    end
    repeat (2) @(negedge clk);
    rdy = 1'b1;
    wait_done(1'b0, lat);
    lsb_req = 1'b0;
    compared++;
    if (wlog.size() - w0 !== 1 || (wlog.size() > w0 && wlog[w0] !== {32'h800, 8'h55})) begin
      mismatched++;
      $display("FAIL rdy_store_once: got %0d writes expected 1 of 0000080055", wlog.size() - w0);
    end
    @(negedge clk);
  endtask

  task automatic test_io_store;
    int lat, w0;
    w0 = wlog.size();
    io_buffer_full = 1'b1;
    lsb_wr = 1'b1; lsb_size = 2'b00; lsb_addr = 32'h30000; lsb_wdata = 32'h41; lsb_req = 1'b1;
`ifdef MEM_ARBITER_IO_STALL_EN
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      compared++;
      if (mem_wr !== 1'b0 || wlog.size() != w0) begin
        mismatched++;
        $display("FAIL io_stall_hold[%0d]: got wr=%b writes=%0d expected wr=0 writes=0", k, mem_wr, wlog.size() - w0);
      end
    end
    io_buffer_full = 1'b0;
    wait_done(1'b0, lat);
    lat += 4;
    compared++;
    if (lat !== 5) begin
      mismatched++;
      $display("FAIL io_stall_latency: got %0d expected 5", lat);
    end
`else
    wait_done(1'b0, lat);
    compared++;
    if (lat !== 2) begin
      mismatched++;
      $display("FAIL io_nostall_latency: got %0d expected 2", lat);
    end
`endif
    lsb_req = 1'b0;
    io_buffer_full = 1'b0;
    compared++;
    if (wlog.size() - w0 !== 1 || (wlog.size() > w0 && wlog[w0] !== {32'h30000, 8'h41})) begin
      mismatched++;
      $display("FAIL io_store_write: got %0d writes expected 1 of 0003000041", wlog.size() - w0);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int lat, n, elat;
    logic [31:0] a, ak, e;
    logic [1:0]  sz;
    lsb_wr = 1'b0;
    for (int i = 0; i < 8; i++) begin
      a  = (i == 0) ? 32'hFFFF_FFFE : $urandom;
      sz = (i == 0) ? 2'b10 : 2'($urandom_range(0, 3));
      n  = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
      e  = '0;
      for (int k = 0; k < n; k++) begin
        ak = a + k;
        ram[ak[11:0]] = 8'($urandom);
        e[8*k +: 8] = ram[ak[11:0]];
      end
      exp_ls.push_back(e);
      lsb_addr = a; lsb_size = sz; lsb_req = 1'b1;
      // After the first, the request is already held in the done cycle and
      // is only accepted on the edge after it.
      elat = (i == 0) ? n + 1 : n + 2;
      wait_done(1'b0, lat);
      compared++;
      if (lat !== elat) begin
        mismatched++;
        $display("FAIL b2b_latency[%0d]: got %0d expected %0d", i, lat, elat);
      end
      e = exp_ls.pop_front();
      compared++;
      if (lsb_rdata !== e) begin
        mismatched++;
        $display("FAIL b2b_rdata[%0d] a=%h sz=%0d: got %h expected %h", i, a, sz, lsb_rdata, e);
      end
    end
    lsb_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) ram[i] = 8'h5A;
    ic_addr = '0; lsb_wr = 1'b0; lsb_size = '0; lsb_addr = '0; lsb_wdata = '0;
    test_reset();
    test_ic_read();
    test_store_half();
    test_arbitration();
    test_clear();
    test_rdy_stall();
    test_io_store();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Owns the single byte-wide RAM port. Arbitrates between the I-cache miss-refill path (4-byte reads) and the load/store buffer (1/2/4-byte reads and writes).
- Serialises each request into consecutive byte accesses, assembles little-endian read data, and returns it with a one-cycle done pulse.
- Sits between the I-cache / LSB and the top-level RAM/IO bus.
- A branch flush aborts speculative reads.

Parameters:
ADDR_W, 32, address width of all address ports.
IO_HI, 2'b11, value of addr[17:16] that marks the memory-mapped IO region.

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
rdy  input  1  global enable; low freezes all state
clear  input  1  branch mispredict flush
ic_req  input  1  I-cache read request, level, held until ic_done
ic_addr  input  ADDR_W  I-cache read address (4 bytes)
ic_done  output  1  one-cycle pulse, ic_data valid
ic_data  output  32  assembled instruction word
lsb_req  input  1  LSB request, level, held until lsb_done
lsb_wr  input  1  1 = store, 0 = load
lsb_size  input  2  00 = byte, 01 = half, 10 = word
lsb_addr  input  ADDR_W  LSB byte address
lsb_wdata  input  32  store data; low bytes are used first
lsb_done  output  1  one-cycle pulse, load data valid or store complete
lsb_rdata  output  32  load data, zero-extended; the LSB sign-extends
mem_din  input  8  RAM read byte, valid the cycle after its address
mem_dout  output  8  RAM write byte
mem_a  output  ADDR_W  RAM byte address
mem_wr  output  1  1 = write
io_buffer_full  input  1  UART FIFO full

Behaviour:
- Reset: state = IDLE, byte counter = 0, last_grant = LSB. All outputs 0.
- States:
  - IDLE: requests sampled here only.
  - IC_RD, LS_RD: byte reads.
  - LS_WR: byte writes.
- Byte count N: N = 4 for the I-cache, and 1/2/4 for the LSB per lsb_size. Byte k is at addr+k, 32-bit wrap.
- Arbitration in IDLE:
  - Only one requester valid: grant it.
  - Both valid: grant the one not in last_grant. last_grant updates on every grant.
- Read:
  - Acceptance edge drives mem_a = addr, mem_wr = 0.
  - Edges 1..N-1 drive mem_a = addr+k and capture mem_din into byte k-1.
  - Edge N captures byte N-1, returns to IDLE, asserts done with data.
  - Done is therefore high in cycle N+1 after acceptance; a 4-byte read has 5-cycle latency.
- Write:
  - Edges 0..N-1 drive mem_a = addr+k, mem_dout = wdata[8k+7:8k], mem_wr = 1.
  - Edge N drives mem_wr = 0, returns to IDLE, asserts lsb_done.
- Done is high for exactly one cycle; ic_data / lsb_rdata hold until the next done of the same port.
- In the cycle a port's done is high, that port's req is ignored. Other-port requests may be granted in that cycle.
- clear:
  - IC_RD or LS_RD: abort, go to IDLE next edge. No done pulse; mem_wr = 0.
  - LS_WR: not aborted, because stores are committed; the write runs to completion.
  - In IDLE: that edge grants nothing.
- rdy low: state, counter and mem_a hold; mem_wr forced 0. On resume the current byte is re-issued.
- Unused upper bytes of lsb_rdata are 0. lsb_size = 11 is treated as word.
- Requests are never queued internally. Deasserting a req mid-transaction has no effect.

Optional Feature:
MEM_ARBITER_IO_STALL_EN:
- Defined: in LS_WR, when lsb_addr[17:16] == IO_HI and io_buffer_full = 1, the current byte is not issued (mem_wr = 0, counter holds) until io_buffer_full = 0. IO reads are unaffected.
- Undefined: io_buffer_full is ignored and writes never stall.

Decomposition:
- The shared config header holds:
  - state encodings `MA_IDLE / `MA_IC_RD / `MA_LS_RD / `MA_LS_WR;
  - size encodings `SZ_B / `SZ_H / `SZ_W;
  - the existing `TRUE/`FALSE/`HIGH/`LOW.
- One sub-module is natural: mem_byte_assembler, a counter-indexed 4-byte shift/insert register with size-based byte count. It is shared by both read paths.

Test Plan:
- ic_req, ic_addr = 0x100, RAM[0x100..0x103] = 13 05 A0 00 -> mem_a sequence 0x100..0x103; ic_done high 5 cycles after grant; ic_data = 0x00A00513.
- lsb store, size = half, addr = 0x200, wdata = 0x1234ABCD -> two mem_wr cycles: (0x200, CD), (0x201, AB); lsb_done on cycle 3; RAM[0x202] untouched.
- ic_req and lsb_req (load byte, 0x300) asserted the same cycle after reset -> ic granted first (last_grant = LSB); lsb granted the edge after ic_done; lsb_rdata = 0x000000xx.
- clear pulsed on read byte 2 of ic fetch 0x400 -> next edge is IDLE, no ic_done. Same clear during a word store -> all 4 bytes written, lsb_done asserted.
- rdy low for 3 cycles mid 4-byte read -> mem_a frozen, mem_wr = 0; correct word delivered, with latency extended by exactly 3.
- With MEM_ARBITER_IO_STALL_EN defined: store byte 0x41 to 0x30000 while io_buffer_full = 1 for 4 cycles -> mem_wr stays 0 until release, then one write; without the macro the write is issued immediately.
